ttl_multimode_reg: RTL and testbench
====================================

# ttl_multimode_reg

Parametrised multi-mode register: the next generation of the team's 8-bit clearable D register. A WIDTH-bit register that can hold, parallel-load, shift, rotate, or count up or down, selected per clock by a 3-bit mode code. It has a clock enable, serial inputs and outputs for cascading, and a terminal-count output. It is used as a drop-in storage, shift or counter stage in simulated TTL-style datapaths and is cascadable through the serial and terminal-count pins.

## Interface
- WIDTH, 8: register width in bits, minimum 2.
- CLR_VALUE, {WIDTH{1'b0}}: value loaded by clear.
- clk  input  1  rising-edge clock.
- clr  input  1  reset, synchronous, active-low; sampled on rising clk.
- en  input  1  clock enable, active-high.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sr_in  input  1  serial input for shift-right; enters at q[WIDTH-1].
- sl_in  input  1  serial input for shift-left; enters at q[0].
- q  output  WIDTH  register contents.
- so_r  output  1  = q[0]; serial output for right-shift cascading.
- so_l  output  1  = q[WIDTH-1]; serial output for left-shift cascading.
- tc  output  1  terminal count, combinational.

## Operation
- Priority at each rising clk:
  - clr == 0: q <= CLR_VALUE, regardless of en and mode.
  - else en == 0: hold.
  - else act per mode.
- mode encoding, applied when en == 1:
  - 000: hold.
  - 001: load, q <= d.
  - 010: shift right, q <= {sr_in, q[WIDTH-1:1]}.
  - 011: shift left, q <= {q[WIDTH-2:0], sl_in}.
  - 100: rotate right, q <= {q[0], q[WIDTH-1:1]}.
  - 101: rotate left, q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110: count up, q <= q + 1 mod 2^WIDTH. All-ones wraps to 0.
  - 111: count down, q <= q - 1 mod 2^WIDTH. 0 wraps to all-ones.
- tc:
  - 1 when en == 1, mode == 110 and q == all-ones.
  - 1 when en == 1, mode == 111 and q == 0.
  - 0 otherwise, including while clr == 0 is pending.
  - Intended to drive en of the next stage in a cascaded counter.
- Unknown inputs (simulation model):
  - Any x/z bit on mode while clr == 1 and en == 1 makes q all-x at the edge.
  - x on d during load propagates bitwise.
  - x on clr at an edge makes q all-x.
  - x on en with a non-hold mode makes q all-x.
- Serial outputs are purely combinational copies of the end bits. They are valid the same delta as q.

## Timing
- Single clock domain. All state changes occur only on rising clk. No asynchronous paths into q.
- Latency: one clock from sampled inputs to the new q. so_r and so_l follow q in the same timestep. tc follows q, mode and en combinationally.
- Reset:
  - Asserting clr for one rising edge is sufficient. After that edge, q = CLR_VALUE, so_r = CLR_VALUE[0], so_l = CLR_VALUE[WIDTH-1].
  - Before the first clr edge, q is x.
  - Deasserting clr takes effect at the next edge: mode acts on that edge if en == 1.
  - clr low mid-count or mid-shift aborts the operation at that edge. No partial update.
- Changing mode between edges has no effect on q until the next edge. tc re-evaluates immediately.
- Zero-delay model. Inputs must be stable at the rising edge. The bench changes stimulus on the inactive clk phase.

## Test plan
- Clear:
  - Power-up q = x.
  - clr = 0, en = x, mode = x, one edge -> q = 00000000, so_r = 0, so_l = 0, tc = 0.
- Load and hold (WIDTH = 8):
  - mode = 001, d = 10101010, en = 1, one edge -> q = 10101010.
  - mode = 001, en = 0, d = 11111111 -> q stays 10101010.
  - mode = 000, en = 1 -> q stays 10101010.
- Shift and rotate:
  - From 10000001, mode = 010, sr_in = 0, 1 edge -> 01000000.
  - From 10000001, mode = 011, sl_in = 1, 1 edge -> 00000011.
  - From 10000001, mode = 100, 1 edge -> 11000000.
  - From 10000001, mode = 101, 1 edge -> 00000011.
  - Eight rotate-right edges from 00000001 -> back to 00000001, with so_r = 1 only at start and end.
- Count wrap and tc:
  - Load 11111110, mode = 110: tc = 0. After 1 edge, q = 11111111 and tc = 1. After the next edge, q = 00000000 and tc = 0.
  - Mode = 111 from 00000000: tc = 1. Next edge -> q = 11111111.
- Cascade:
  - Two 4-bit instances with low.tc driving high.en, both in mode 110, cleared.
  - After 16 edges, {high, low} = 00010000.
  - After 255 edges, {high, low} = 11111111 with both tc = 1.
- Reset priority mid-operation:
  - Counting up at q = 00000111, clr = 0 at the next edge with en = 1 -> q = 00000000, not 00001000.
  - With CLR_VALUE = 8'h5A, clr -> q = 01011010.

Source files
------------

// File: rtl/ttl_multimode_reg.sv
// Purpose : WIDTH-bit multi-mode register (hold/load/shift/rotate/count up/down)
//           with clock enable, serial cascade pins and a terminal-count output.
// Latency : one clk from sampled inputs to q; so_r/so_l/tc are combinational.
// Backpressure: none; en is the only stall (en == 0 holds q).
//
// Ports:
//   clk    rising-edge clock
//   clr    synchronous active-low clear, loads CLR_VALUE; beats en and mode
//   en     active-high clock enable
//   mode   000 hold, 001 load, 010 shr, 011 shl, 100 ror, 101 rol,
//          110 count up, 111 count down
//   d      parallel load data
//   sr_in  serial in for shift right (enters at q[WIDTH-1])
//   sl_in  serial in for shift left (enters at q[0])
//   q      register contents
//   so_r   q[0], cascade output for right shifts
//   so_l   q[WIDTH-1], cascade output for left shifts
//   tc     terminal count: counting with en=1 and q at its wrap point

`timescale 1ns/1ps

module ttl_multimode_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SHL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_UP   = 3'b110;
  localparam logic [2:0] M_DN   = 3'b111;

  logic [WIDTH-1:0] q_nxt;

  // Next value for an enabled, non-cleared edge. The default arm is only
  // reachable in 4-state simulation with x/z on mode and poisons q.
  always_comb begin
    q_nxt = q;
    case (mode)
      M_HOLD:  q_nxt = q;
      M_LOAD:  q_nxt = d;
      M_SHR:   q_nxt = {sr_in, q[WIDTH-1:1]};
      M_SHL:   q_nxt = {q[WIDTH-2:0], sl_in};
      M_ROR:   q_nxt = {q[0], q[WIDTH-1:1]};
      M_ROL:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      M_UP:    q_nxt = q + ONE;
      M_DN:    q_nxt = q - ONE;
      default: q_nxt = {WIDTH{1'bx}};
    endcase
  end

  // Clear beats enable beats mode. The default arms cover x/z on clr or en
  // in simulation: unknown clear poisons q, unknown enable poisons q unless
  // the selected mode is hold (in which case either branch keeps q).
  always_ff @(posedge clk) begin
    case (clr)
      1'b0: q <= CLR_VALUE;
      1'b1: begin
        case (en)
          1'b1:    q <= q_nxt;
          1'b0:    q <= q;
          default: q <= (mode == M_HOLD) ? q : {WIDTH{1'bx}};
        endcase
      end
      default: q <= {WIDTH{1'bx}};
    endcase
  end

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

  // Qualified by clr so a pending clear never ripples an enable into the
  // next cascaded stage.
  assign tc = clr & en & (((mode == M_UP) & (&q)) | ((mode == M_DN) & ~(|q)));

endmodule

// File: tb/tb_ttl_multimode_reg.sv
`timescale 1ns/1ps

module tb_ttl_multimode_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main 8-bit instance and a CLR_VALUE = 8'h5A sibling sharing its inputs.
  logic       clr, en, sr_in, sl_in;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q, qa;
  logic       so_r, so_l, tc, so_ra, so_la, tca;

  // 4-bit cascade pair: low.tc drives high.en.
  logic       clr_c;
  logic [3:0] ql, qh;
  logic       sorl, soll, tcl, sorh, solh, tch;

  ttl_multimode_reg #(.WIDTH(8)) u_dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .d(d),
    .sr_in(sr_in), .sl_in(sl_in), .q(q), .so_r(so_r), .so_l(so_l), .tc(tc)
  );

  ttl_multimode_reg #(.WIDTH(8), .CLR_VALUE(8'h5A)) u_dut5a (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .d(d),
    .sr_in(sr_in), .sl_in(sl_in), .q(qa), .so_r(so_ra), .so_l(so_la), .tc(tca)
  );

  ttl_multimode_reg #(.WIDTH(4)) u_low (
    .clk(clk), .clr(clr_c), .en(1'b1), .mode(3'b110), .d(4'h0),
    .sr_in(1'b0), .sl_in(1'b0), .q(ql), .so_r(sorl), .so_l(soll), .tc(tcl)
  );

  ttl_multimode_reg #(.WIDTH(4)) u_high (
    .clk(clk), .clr(clr_c), .en(tcl), .mode(3'b110), .d(4'h0),
    .sr_in(1'b0), .sl_in(1'b0), .q(qh), .so_r(sorh), .so_l(solh), .tc(tch)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'b001;
    en   = 1'b1;
    d    = v;
    tick();
  endtask

  initial begin
    clr   = 1'b0;
    en    = 1'bx;
    mode  = 3'bxxx;
    d     = 8'h00;
    sr_in = 1'b0;
    sl_in = 1'b0;
    clr_c = 1'b0;
    #2;

    // Clear with en/mode unknown
    tick();
    check("clr_q",    {24'd0, q},  32'h00);
    check("clr_so_r", {31'd0, so_r}, 32'h0);
    check("clr_so_l", {31'd0, so_l}, 32'h0);
    check("clr_tc",   {31'd0, tc},   32'h0);
    check("clr_5a",   {24'd0, qa}, 32'h5A);

    // Load and hold
    clr = 1'b1;
    load(8'hAA);
    check("load_aa", {24'd0, q}, 32'hAA);
    en = 1'b0; d = 8'hFF;
    tick();
    check("hold_en0", {24'd0, q}, 32'hAA);
    en = 1'b1; mode = 3'b000;
    tick();
    check("hold_mode0", {24'd0, q}, 32'hAA);
    check("so_l_aa", {31'd0, so_l}, 32'h1);
    check("so_r_aa", {31'd0, so_r}, 32'h0);

    // Shift and rotate from 8'h81
    load(8'h81); mode = 3'b010; sr_in = 1'b0; tick();
    check("shr", {24'd0, q}, 32'h40);
    load(8'h81); mode = 3'b011; sl_in = 1'b1; tick();
    check("shl", {24'd0, q}, 32'h03);
    load(8'h81); mode = 3'b100; tick();
    check("ror", {24'd0, q}, 32'hC0);
    load(8'h81); mode = 3'b101; tick();
    check("rol", {24'd0, q}, 32'h03);
    load(8'h81); mode = 3'b010; sr_in = 1'b1; tick();
    check("shr_in1", {24'd0, q}, 32'hC0);

    // Eight rotate-right edges from 8'h01
    load(8'h01);
    mode = 3'b100;
    check("ror8_so_r_start", {31'd0, so_r}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("ror8_so_r_%0d", i), {31'd0, so_r}, (i == 8) ? 32'h1 : 32'h0);
    end
    check("ror8_q", {24'd0, q}, 32'h01);

    // Count wrap and tc
    load(8'hFE);
    mode = 3'b110;
    #1;
    check("up_tc_fe", {31'd0, tc}, 32'h0);
    tick();
    check("up_q_ff",  {24'd0, q},  32'hFF);
    check("up_tc_ff", {31'd0, tc}, 32'h1);
    en = 1'b0;
    #1;
    check("up_tc_en0", {31'd0, tc}, 32'h0);
    en = 1'b1;
    tick();
    check("up_q_wrap",  {24'd0, q},  32'h00);
    check("up_tc_wrap", {31'd0, tc}, 32'h0);
    mode = 3'b111;
    #1;
    check("dn_tc_00", {31'd0, tc}, 32'h1);
    tick();
    check("dn_q_wrap", {24'd0, q}, 32'hFF);
    check("dn_tc_ff", {31'd0, tc}, 32'h0);

    // Reset priority mid-count
    load(8'h05);
    mode = 3'b110;
    tick();
    tick();
    check("cnt_07", {24'd0, q}, 32'h07);
    clr = 1'b0;
    tick();
    check("clr_mid_cnt", {24'd0, q},  32'h00);
    check("clr_5a_mid",  {24'd0, qa}, 32'h5A);

    // tc suppressed while a clear is pending
    clr = 1'b1;
    load(8'hFF);
    mode = 3'b110;
    clr  = 1'b0;
    #1;
    check("tc_clr_pending", {31'd0, tc}, 32'h0);
    tick();
    check("clr_from_ff", {24'd0, q}, 32'h00);
    clr = 1'b1;

    // Cascade of two 4-bit counters
    check("casc_clr", {24'd0, qh, ql}, 32'h00);
    clr_c = 1'b1;
    repeat (16) tick();
    check("casc_16", {24'd0, qh, ql}, 32'h10);
    repeat (239) tick();
    check("casc_255", {24'd0, qh, ql}, 32'hFF);
    check("casc_tcl", {31'd0, tcl}, 32'h1);
    check("casc_tch", {31'd0, tch}, 32'h1);
    tick();
    check("casc_wrap", {24'd0, qh, ql}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
